// File: rtl/divrem_pkg.sv
// Shared types and constants for the 128-bit val/rdy divide/remainder interface
// and its request-source / checker.
package divrem_pkg;

  localparam int NBITS        = 64;
  localparam int DIVIDEND_LSB = 64;
  localparam int QUOT_LSB     = 64;

  typedef struct packed {
    logic [NBITS-1:0] dividend;
    logic [NBITS-1:0] divisor;
  } divrem_req_t;

  typedef struct packed {
    logic [NBITS-1:0] quotient;
    logic [NBITS-1:0] remainder;
  } divrem_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-shifting Galois LFSR, taps 64,63,61,60.
  function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
  endfunction

endpackage

// File: rtl/divrem_inflight_fifo.sv
// Small synchronous FIFO holding the operands of requests still awaiting a
// response; the head is visible combinationally so it can be checked on pop.
module divrem_inflight_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/divrem_req_src.sv
// Divide/remainder request source and invariant checker. Optional random
// response backpressure is enabled with `define DIVREM_SRC_RAND_STALL_EN.
module divrem_req_src
  import divrem_pkg::*;
#(
  parameter int          NBITS = divrem_pkg::NBITS,
  parameter int          DEPTH = 4,
  parameter logic [63:0] SEED  = 64'hACE1_2468_1357_BDF9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        num_reqs,
  output logic               busy,
  output logic               done,
  output logic [15:0]        err_count,
  output logic [15:0]        resp_count,
  output logic               req_val,
  input  logic               req_rdy,
  output logic [2*NBITS-1:0] req_msg,
  input  logic               resp_val,
  output logic               resp_rdy,
  input  logic [2*NBITS-1:0] resp_msg
);

  state_e       state_q;
  logic [15:0]  num_q;
  logic [15:0]  issued_q;
  logic [15:0]  resp_count_q;
  logic [15:0]  err_count_q;
  logic [63:0]  lfsr_q;
  logic [63:0]  lfsr_d;

  divrem_req_t  req_s;
  divrem_resp_t resp_s;
  logic [2*NBITS-1:0] head_raw;
  logic [NBITS-1:0]   head_dividend;
  logic [NBITS-1:0]   head_divisor;
  logic         fifo_full;
  logic         fifo_empty;
  logic         req_fire;
  logic         resp_fire;
  logic         check_ok;
  logic         err_inc;
  logic [2*NBITS-1:0] recon;

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign err_count  = err_count_q;
  assign resp_count = resp_count_q;

  // Operands come straight from the current LFSR state; divisor never zero.
  assign req_s.dividend = lfsr_q;
  assign req_s.divisor  = (lfsr_q[63:32] == 32'd0) ? 64'd1 : {32'd0, lfsr_q[63:32]};
  assign req_msg        = req_s;
  assign lfsr_d         = lfsr64_next(lfsr_q);

  assign req_val   = (state_q == RUN) && (issued_q < num_q) && !fifo_full;
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

`ifdef DIVREM_SRC_RAND_STALL_EN
  logic [15:0] lfsr16_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr16_q <= 16'hBEEF;
    else       lfsr16_q <= lfsr16_q[0] ? ((lfsr16_q >> 1) ^ 16'hB400) : (lfsr16_q >> 1);
  end

  assign resp_rdy = (state_q == RUN) && (lfsr16_q[1:0] != 2'b00);
`else
  assign resp_rdy = (state_q == RUN);
`endif

  divrem_inflight_fifo #(.W(2*NBITS), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (req_fire),
    .din_i   (req_msg),
    .pop_i   (resp_fire),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_raw)
  );

  assign head_dividend    = head_raw[DIVIDEND_LSB +: NBITS];
  assign head_divisor     = head_raw[NBITS-1:0];
  assign resp_s.quotient  = resp_msg[QUOT_LSB +: NBITS];
  assign resp_s.remainder = resp_msg[NBITS-1:0];

  // Full-width reconstruction: q*d + r cannot wrap at 2*NBITS bits.
  assign recon    = ({{NBITS{1'b0}}, resp_s.quotient} * {{NBITS{1'b0}}, head_divisor})
                  + {{NBITS{1'b0}}, resp_s.remainder};
  assign check_ok = (resp_s.remainder < head_divisor)
                 && (recon == {{NBITS{1'b0}}, head_dividend});
  assign err_inc  = resp_fire && (fifo_empty || !check_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      num_q        <= '0;
      issued_q     <= '0;
      resp_count_q <= '0;
      err_count_q  <= '0;
      lfsr_q       <= SEED;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q        <= num_reqs;
            issued_q     <= '0;
            resp_count_q <= '0;
            err_count_q  <= '0;
            state_q      <= (num_reqs == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (req_fire) begin
            issued_q <= issued_q + 16'd1;
            lfsr_q   <= lfsr_d;
          end
          if (resp_fire && !fifo_empty) resp_count_q <= resp_count_q + 16'd1;
          if (err_inc && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
          if ((issued_q == num_q) && (resp_count_q == num_q)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divrem_req_src.sv
// Directed bench for divrem_req_src: a behavioural divider answers requests
// one cycle later, with knobs for hold-off, corrupted and spurious responses.
module tb_divrem_req_src;

  localparam logic [63:0] SEED = 64'hACE1_2468_1357_BDF9;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  num_reqs;
  logic         busy, done;
  logic [15:0]  err_count, resp_count;
  logic         req_val, req_rdy;
  logic [127:0] req_msg;
  logic         resp_val, resp_rdy;
  logic [127:0] resp_msg;

  divrem_req_src dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_reqs   (num_reqs),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .resp_count (resp_count),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_msg   (resp_msg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [127:0] mq[$];
  logic [127:0] req_log[$];
  int  resp_sent, fault_at, hold_cycles, req_hs, resp_hs;
  bit  inject, rdy_en, saw_req_val;

  task automatic model_clear();
    mq.delete();
    req_log.delete();
    resp_sent = 0; fault_at = -1; hold_cycles = 0;
    req_hs = 0; resp_hs = 0; inject = 0; saw_req_val = 0;
  endtask

  // One clock of the divider model; entered and left at a falling edge.
  task automatic step();
    bit rf, sf, inj;
    logic [63:0] a, d;
    inj = inject;
    inject = 0;
    req_rdy  = rdy_en;
    resp_val = 1'b0;
    resp_msg = '0;
    if (inj) resp_val = 1'b1;
    else if (hold_cycles > 0) hold_cycles--;
    else if (mq.size() > 0) begin
      resp_val = 1'b1;
      resp_msg = mq[0];
      if (resp_sent == fault_at) resp_msg[63:0] = mq[0][63:0] + 64'd1;
    end
    #1;
    rf = req_val && req_rdy;
    sf = resp_val && resp_rdy;
    if (req_val) saw_req_val = 1;
    if (rf) req_log.push_back(req_msg);
    @(posedge clk);
    if (sf && !inj) begin
      void'(mq.pop_front());
      resp_sent++;
      resp_hs++;
    end
    if (rf) begin
      a = req_log[$][127:64];
      d = req_log[$][63:0];
      mq.push_back({a / d, a % d});
      req_hs++;
    end
    @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] n);
    req_rdy = 1'b0; resp_val = 1'b0;
    start = 1'b1; num_reqs = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1; break; end
      step();
    end
    if (!ok) ok = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_reqs = '0;
    req_rdy = 1'b0; resp_val = 1'b0; resp_msg = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({busy, done, req_val, resp_rdy} !== 4'b0000) begin fails++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, req_val, resp_rdy}); end
    tests++; if (err_count !== 16'd0 || resp_count !== 16'd0) begin fails++;
      $display("FAIL reset_counts: got err=%0d resp=%0d expected 0/0", err_count, resp_count); end
    $display("[TB] reset: busy=%b done=%b", busy, done);
  endtask

  task automatic test_zero_reqs();
    model_clear();
    start_run(16'd0);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL zero_done: got done=%b busy=%b expected 1/0", done, busy); end
    repeat (3) step();
    tests++; if (saw_req_val !== 1'b0 || err_count !== 16'd0) begin fails++;
      $display("FAIL zero_quiet: got req_val_seen=%b err=%0d expected 0/0", saw_req_val, err_count); end
    $display("[TB] zero_reqs: done=%b", done);
  endtask

  task automatic test_stream();
    bit ok;
    model_clear();
    start_run(16'd100);
    tests++; if (req_val !== 1'b1) begin fails++;
      $display("FAIL first_req_latency: got req_val=%b expected 1", req_val); end
    rdy_en = 1;
    repeat (10) step();
    tests++; if (req_hs != 10) begin fails++;
      $display("FAIL back_to_back: got %0d requests in 10 cycles expected 10", req_hs); end
    run_until_done(1000, ok);
    tests++; if (!ok) begin fails++;
      $display("FAIL stream_timeout: got done=%b expected 1", done); end
    tests++; if (resp_count !== 16'd100 || err_count !== 16'd0) begin fails++;
      $display("FAIL stream_counts: got resp=%0d err=%0d expected 100/0", resp_count, err_count); end
    tests++; if (req_hs != 100 || resp_hs != 100) begin fails++;
      $display("FAIL stream_handshakes: got req=%0d resp=%0d expected 100/100", req_hs, resp_hs); end
    tests++; if (req_log[0] !== {SEED, 64'h0000_0000_ACE1_2468}) begin fails++;
      $display("FAIL first_msg: got %h expected %h", req_log[0], {SEED, 64'h0000_0000_ACE1_2468}); end
    tests++; if (req_log[1] !== {64'h8E70_9234_09AB_DEFC, 64'h0000_0000_8E70_9234}) begin fails++;
      $display("FAIL second_msg: got %h expected 8e70923409abdefc000000008e709234", req_log[1]); end
    $display("[TB] stream: resp=%0d err=%0d", resp_count, err_count);
  endtask

  task automatic test_fault();
    bit ok;
    model_clear();
    start_run(16'd5);
    fault_at = 2;
    rdy_en = 1;
    run_until_done(200, ok);
    tests++; if (!ok) begin fails++;
      $display("FAIL fault_timeout: got done=%b expected 1", done); end
    tests++; if (err_count !== 16'd1 || resp_count !== 16'd5) begin fails++;
      $display("FAIL fault_counts: got err=%0d resp=%0d expected 1/5", err_count, resp_count); end
    $display("[TB] fault: err=%0d resp=%0d", err_count, resp_count);
  endtask

  task automatic test_fifo_full();
    bit ok;
    model_clear();
    start_run(16'd8);
    hold_cycles = 20;
    rdy_en = 1;
    repeat (10) step();
    tests++; if (req_hs != 4 || req_val !== 1'b0) begin fails++;
      $display("FAIL full_stall: got issued=%0d req_val=%b expected 4/0", req_hs, req_val); end
    repeat (11) step();
    tests++; if (req_hs != 4 || req_val !== 1'b1) begin fails++;
      $display("FAIL full_resume: got issued=%0d req_val=%b expected 4/1", req_hs, req_val); end
    run_until_done(200, ok);
    tests++; if (!ok || err_count !== 16'd0 || resp_count !== 16'd8) begin fails++;
      $display("FAIL full_finish: got done=%b err=%0d resp=%0d expected 1/0/8", done, err_count, resp_count); end
    $display("[TB] fifo_full: issued=%0d resp=%0d", req_hs, resp_count);
  endtask

  task automatic test_spurious();
    bit ok;
    model_clear();
    rdy_en = 0;
    start_run(16'd2);
    inject = 1;
    step();
    tests++; if (err_count !== 16'd1 || resp_count !== 16'd0) begin fails++;
      $display("FAIL spurious: got err=%0d resp=%0d expected 1/0", err_count, resp_count); end
    rdy_en = 1;
    run_until_done(100, ok);
    tests++; if (!ok || err_count !== 16'd1 || resp_count !== 16'd2) begin fails++;
      $display("FAIL spurious_finish: got done=%b err=%0d resp=%0d expected 1/1/2", done, err_count, resp_count); end
    $display("[TB] spurious: err=%0d resp=%0d", err_count, resp_count);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    model_clear();
    start_run(16'd50);
    rdy_en = 1;
    repeat (6) step();
    tests++; if (busy !== 1'b1 || resp_count === 16'd0) begin fails++;
      $display("FAIL pre_reset: got busy=%b resp=%0d expected 1/nonzero", busy, resp_count); end
    reset = 1'b1;
    #1;
    tests++; if ({busy, done, req_val, resp_rdy} !== 4'b0000) begin fails++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {busy, done, req_val, resp_rdy}); end
    tests++; if (err_count !== 16'd0 || resp_count !== 16'd0) begin fails++;
      $display("FAIL mid_reset_counts: got err=%0d resp=%0d expected 0/0", err_count, resp_count); end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    start_run(16'd3);
    tests++; if (req_val !== 1'b1 || req_msg[127:64] !== SEED) begin fails++;
      $display("FAIL seed_restart: got req_val=%b dividend=%h expected 1/%h", req_val, req_msg[127:64], SEED); end
    run_until_done(100, ok);
    tests++; if (!ok || err_count !== 16'd0 || resp_count !== 16'd3) begin fails++;
      $display("FAIL restart_finish: got done=%b err=%0d resp=%0d expected 1/0/3", done, err_count, resp_count); end
    $display("[TB] reset_mid_run: resp=%0d", resp_count);
  endtask

  initial begin
    test_reset();
    test_zero_reqs();
    test_stream();
    test_fault();
    test_fifo_full();
    test_spurious();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
